// File: rtl/component_scheduler_pkg.sv
// component_scheduler_pkg: FSM states, component encodings and block size shared by the scheduler
package component_scheduler_pkg;
    typedef enum logic [2:0] {IDLE, PREP, RUN, NEXT, DONE} state_t;
    localparam logic [1:0] COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2;
    localparam logic [31:0] BLOCK_WORDS = 32'd64;
endpackage

// File: rtl/component_scheduler_bit_accumulator.sv
// bit_accumulator: 32-bit bit counter that sticks at all-ones instead of wrapping
module bit_accumulator (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] add,
    output logic [31:0] sum
);
    logic [32:0] total;
    assign total = {1'b0, sum} + {1'b0, add};
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) sum <= '0;
        else if (clear) sum <= '0;
        else if (en) sum <= total[32] ? '1 : total[31:0];
endmodule

// File: rtl/component_scheduler.sv
// component_scheduler: runs Y, Cb, Cr passes per slice; COMPONENT_SCHEDULER_TIMEOUT_EN adds a RUN watchdog
module component_scheduler
    import component_scheduler_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        slice_start,
    input  logic [31:0] slice_offset,
    input  logic [31:0] luma_block_num,
    input  logic [31:0] chroma_block_num,
    input  logic        sb_enable,
    input  logic [63:0] sb_size_of_bit,
    input  logic        sb_flush,
    output logic        component_reset_n,
    output logic        is_y,
    output logic [31:0] comp_block_num,
    output logic [31:0] comp_offset,
    output logic [1:0]  comp_index,
    output logic        busy,
    output logic        slice_done,
    output logic [31:0] y_bits,
    output logic [31:0] cb_bits,
    output logic [31:0] cr_bits,
    output logic        timeout_err
);
    state_t state, state_n;
    logic [3:0] prep_cnt;
    logic [31:0] offset_q, luma_q, chroma_q, cb_offset;
    logic [31:0] bits [3];
    logic start_ok, in_run, to_fire, unused_hi;

    assign start_ok = state == IDLE && slice_start;
    assign in_run = state == RUN;
    assign busy = state != IDLE;
    assign slice_done = state == DONE;
    assign is_y = comp_index == COMP_Y;
    assign cb_offset = offset_q + luma_q * BLOCK_WORDS;
    assign comp_offset = comp_index == COMP_Y ? offset_q :
                         comp_index == COMP_CB ? cb_offset : cb_offset + chroma_q * BLOCK_WORDS;
    assign comp_block_num = is_y ? luma_q : chroma_q;
    assign unused_hi = ^{sb_size_of_bit[63:32], TIMEOUT_CYCLES != 0};
    assign y_bits = bits[0];
    assign cb_bits = bits[1];
    assign cr_bits = bits[2];

`ifdef COMPONENT_SCHEDULER_TIMEOUT_EN
    logic [31:0] run_cnt;
    logic timeout_q;
    assign to_fire = in_run && !sb_flush && run_cnt == 32'(TIMEOUT_CYCLES);
    assign timeout_err = timeout_q;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            run_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_cnt <= in_run ? run_cnt + 32'd1 : '0;
            if (start_ok) timeout_q <= 1'b0;
            else if (to_fire) timeout_q <= 1'b1;
        end
`else
    assign to_fire = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = slice_start ? PREP : IDLE;
            PREP:    state_n = prep_cnt == 4'(RESET_CYCLES - 1) ? RUN : PREP;
            RUN:     state_n = to_fire ? DONE : sb_flush ? NEXT : RUN;
            NEXT:    state_n = comp_index == COMP_CR ? DONE : PREP;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // component reset is registered from the next state so it lines up exactly with PREP
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            component_reset_n <= 1'b0;
            prep_cnt <= '0;
            comp_index <= COMP_Y;
            offset_q <= '0;
            luma_q <= '0;
            chroma_q <= '0;
        end else begin
            component_reset_n <= state_n != PREP && !to_fire;
            prep_cnt <= state == PREP ? prep_cnt + 4'd1 : 4'd0;
            if (start_ok) begin
                comp_index <= COMP_Y;
                offset_q <= slice_offset;
                luma_q <= luma_block_num;
                chroma_q <= chroma_block_num;
            end else if (state == NEXT && comp_index != COMP_CR) begin
                comp_index <= comp_index + 2'd1;
            end
        end

    for (genvar c = 0; c < 3; c++) begin : g_acc
        bit_accumulator u_acc (
            .clock   (clock),
            .reset_n (reset_n),
            .clear   (start_ok),
            .en      (in_run && sb_enable && comp_index == 2'(c)),
            .add     (sb_size_of_bit[31:0]),
            .sum     (bits[c])
        );
    end
endmodule

// File: doc/component_scheduler.md
COMPONENT_SCHEDULER -- requirements
Module: component_scheduler

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2: cycles component_reset_n is held low before each component pass (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: watchdog limit per pass, used only when the macro in REQ-019 is defined.
REQ-003 SHALL have the port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have the port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have these inputs:
- slice_start, 1 bit: start pulse.
- slice_offset, 32 bits: word offset of the slice's Y data.
- luma_block_num, 32 bits: Y blocks.
- chroma_block_num, 32 bits: blocks per chroma plane.
REQ-006 SHALL have these inputs from the component datapath: sb_enable (1 bit), sb_size_of_bit (64 bits), sb_flush (1 bit, end-of-pass marker).
REQ-007 SHALL have these outputs to the component datapath:
- component_reset_n, 1 bit.
- is_y, 1 bit.
- comp_block_num, 32 bits.
- comp_offset, 32 bits.
REQ-008 SHALL have these status outputs:
- comp_index, 2 bits: 0 = Y, 1 = Cb, 2 = Cr.
- busy, 1 bit.
- slice_done, 1 bit: single-cycle pulse.
- y_bits, cb_bits, cr_bits, 32 bits each.
- timeout_err, 1 bit.

Function
REQ-009 SHALL implement states IDLE, PREP, RUN, NEXT, DONE.
- IDLE: slice_start goes to PREP with comp_index = 0, and clears y_bits/cb_bits/cr_bits and timeout_err.
- PREP: holds component_reset_n low for exactly RESET_CYCLES cycles, then goes to RUN.
- RUN: releases component_reset_n; sb_flush goes to NEXT.
- NEXT: one cycle; if comp_index is 2, go to DONE, else increment comp_index and go to PREP.
- DONE: pulses slice_done for one cycle and returns to IDLE.
REQ-010 SHALL drive comp_block_num and comp_offset per pass; both are stable for the whole of PREP and RUN:
- Y: comp_block_num = luma_block_num, comp_offset = slice_offset.
- Cb: comp_block_num = chroma_block_num, comp_offset = slice_offset + 64*luma_block_num.
- Cr: comp_block_num = chroma_block_num, comp_offset = Cb offset + 64*chroma_block_num.
REQ-011 SHALL compute offsets modulo 2^32 (wrap, no error).
REQ-012 SHALL drive is_y = 1 only when comp_index is 0.
REQ-013 SHALL capture slice_offset, luma_block_num and chroma_block_num on the accepted slice_start; later input changes SHALL NOT affect the running slice.
REQ-014 SHALL, in RUN, add sb_size_of_bit[31:0] to the current component's bit counter on each cycle with sb_enable = 1, saturating at 32'hFFFF_FFFF.
REQ-015 SHALL, when sb_enable and sb_flush coincide, count that cycle's bits before leaving RUN.
REQ-016 SHALL ignore slice_start outside IDLE; a start in the DONE cycle is dropped.
REQ-017 SHALL ignore sb_enable and sb_flush outside RUN.
REQ-018 SHALL hold busy = 1 in every state except IDLE.

Configuration
REQ-019 SHALL, with COMPONENT_SCHEDULER_TIMEOUT_EN defined, run a per-pass RUN cycle counter.
- When the counter reaches TIMEOUT_CYCLES without sb_flush: set timeout_err (sticky until the next accepted start), assert component_reset_n low, and go to DONE.
- Without the macro: no counter is built, timeout_err is tied 0, and RUN waits indefinitely.

Reset
REQ-020 SHALL, while reset_n is low, force:
- state IDLE;
- component_reset_n = 0;
- is_y = 1;
- comp_index, comp_block_num, comp_offset = 0;
- busy, slice_done, timeout_err = 0;
- all bit counters = 0.
REQ-021 SHALL, on reset assertion mid-slice, abort immediately with no slice_done pulse.
REQ-022 SHALL, after reset release, remain in IDLE until a new slice_start.

Structure
REQ-023 SHALL place these in the shared encoder package:
- the state enum type;
- the comp_index encodings (COMP_Y, COMP_CB, COMP_CR);
- the block-size constant BLOCK_WORDS = 64.
REQ-024 SHALL factor the saturating 32-bit accumulator into one sub-module, bit_accumulator, instantiated three times.

Verification
REQ-025 SHALL cover a normal slice:
- Stimulus: start with offset 0, luma 4, chroma 2; three sb_enable pulses of 5 bits per pass, then flush.
- Response: comp_offset sequence 0, 256, 384; y_bits = cb_bits = cr_bits = 15; one slice_done pulse.
REQ-026 SHALL cover reset timing: with RESET_CYCLES = 2, component_reset_n is low for exactly 2 cycles before each of the 3 RUN phases.
REQ-027 SHALL cover boundary cases:
- sb_enable with size 7 in the same cycle as sb_flush: that 7 is counted.
- sb_enable pulses while in PREP: not counted.
- slice_start while busy: no effect.
REQ-028 SHALL cover saturation: 32'hFFFF_FFF0 preloaded via large sizes, then add 32 -> counter reads 32'hFFFF_FFFF.
REQ-029 SHALL cover mid-slice reset: reset_n asserted during the Cb RUN -> all outputs at reset values and no slice_done pulse.
REQ-030 SHALL cover timeout: with COMPONENT_SCHEDULER_TIMEOUT_EN defined and TIMEOUT_CYCLES = 100, withhold flush during Y -> timeout_err = 1 and slice_done 101 cycles after entering RUN.
